fpu_issue_scheduler: RTL and testbench

//  Issue controller in front of the pipelined FPU (E1-E2-E3-WB). Mirrors FPU stage occupancy and detects RAW hazards
//  on FPR sources. Selects operand forwarding from E3 result (ed) or WB data (wd), and stalls ID when a result is
//  not yet available or the shared iterative fdiv/fsqrt unit is occupied. Issue is registered into E1.

---
 rtl/fpu_issue_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_fpu_issue_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_issue_scheduler
//   Issue controller in front of the pipelined FPU (E1-E2-E3-WB). Mirrors FPU
//   stage occupancy with destination tags and detects RAW hazards on FPR
//   sources. It selects operand forwarding from the E3 result (ed) or the WB
//   data (wd). It stalls ID when a needed result is not yet on ed, or when the
//   shared iterative fdiv/fsqrt unit is occupied.
//
// Ports
//   clk, clrn          clock, asynchronous active-low reset
//   id_valid_i         ID holds a valid FP instruction
//   id_fc_i[2:0]       fp control (000 add,001 sub,010 mul,011 itof,
//                      100 div,101 ftoi,110 sqrt)
//   id_fs_i/id_use_fs_i  source A FPR number / source A is read
//   id_ft_i/id_use_ft_i  source B FPR number / source B is read
//   id_fd_i/id_wf_i      destination FPR number / instruction writes an FPR
//   pipe_en_i          FPU pipeline advance
//   flush_i            cancel the instruction in ID
//   st_id_o            stall ID/IF this cycle (combinational)
//   fwd_a_o, fwd_b_o   operand select: 00 regfile, 01 ed, 10 wd (combinational)
//   iss_wf_o           write enable handed to E1 (combinational)
//   ds_busy_o          iterative unit occupied (registered)
//   ds_cnt_o           remaining iterative cycles (registered)
//   stall_cnt_o        saturating count of stalled ID cycles (registered)
// ---------------------------------------------------------------------------
module fpu_issue_scheduler #(
  parameter int unsigned DIV_LAT  = 14,
  parameter int unsigned SQRT_LAT = 14,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_valid_i,
  input  logic [2:0]       id_fc_i,
  input  logic [4:0]       id_fs_i,
  input  logic             id_use_fs_i,
  input  logic [4:0]       id_ft_i,
  input  logic             id_use_ft_i,
  input  logic [4:0]       id_fd_i,
  input  logic             id_wf_i,
  input  logic             pipe_en_i,
  input  logic             flush_i,
  output logic             st_id_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             iss_wf_o,
  output logic             ds_busy_o,
  output logic [4:0]       ds_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned FC_W  = 3;
  localparam int unsigned DS_W  = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_ED = 2'b01;
  localparam logic [1:0] FWD_WD = 2'b10;

  localparam logic [FC_W-1:0] FC_DIV  = 3'b100;
  localparam logic [FC_W-1:0] FC_SQRT = 3'b110;

  // Tag carried by E1..E3; WB only needs the destination for forwarding.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] num;
    logic [FC_W-1:0]  fc;
  } tag_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] num;
  } wb_tag_t;

  tag_t    e1_q, e1_d;
  tag_t    e2_q, e2_d;
  tag_t    e3_q, e3_d;
  wb_tag_t wb_q, wb_d;

  logic            ds_busy_q, ds_busy_d;
  logic [DS_W-1:0] ds_cnt_q,  ds_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [2:0] res_a, res_b;
  logic       raw_stall;
  logic       struct_stall;
  logic       is_ds_op;
  logic       ds_busy_rep;
  logic       st_id;
  logic       issue;

  // Hazard resolution for one source: {stall, fwd_sel}. The youngest
  // matching stage wins; a hit in E1 or E2 cannot be forwarded yet.
  function automatic logic [2:0] resolve(
    input logic             use_s,
    input logic [REG_W-1:0] s,
    input tag_t             t1,
    input tag_t             t2,
    input tag_t             t3,
    input wb_tag_t          tw
  );
    logic [2:0] r;
    r = {1'b0, FWD_RF};
    if (use_s) begin
      if ((t1.v && (t1.num == s)) || (t2.v && (t2.num == s))) begin
        r = {1'b1, FWD_RF};
      end else if (t3.v && (t3.num == s)) begin
        r = {1'b0, FWD_ED};
      end else if (tw.v && (tw.num == s)) begin
        r = {1'b0, FWD_WD};
      end
    end
    return r;
  endfunction

  // Hazard detection, stall and issue decision.
  always_comb begin
    res_a        = resolve(id_use_fs_i, id_fs_i, e1_q, e2_q, e3_q, wb_q);
    res_b        = resolve(id_use_ft_i, id_ft_i, e1_q, e2_q, e3_q, wb_q);
    raw_stall    = res_a[2] | res_b[2];
    is_ds_op     = (id_fc_i == FC_DIV) || (id_fc_i == FC_SQRT);
    ds_busy_rep  = ds_busy_q | (ds_cnt_q != '0);
    struct_stall = is_ds_op & ds_busy_rep;
    st_id        = id_valid_i & ~flush_i & (raw_stall | struct_stall);
    issue        = id_valid_i & ~flush_i & ~st_id & pipe_en_i;
  end

  assign st_id_o     = st_id;
  assign fwd_a_o     = res_a[1:0];
  assign fwd_b_o     = res_b[1:0];
  assign iss_wf_o    = id_wf_i & issue;
  assign ds_busy_o   = ds_busy_rep;
  assign ds_cnt_o    = ds_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  // Stage tag shift; a bubble enters E1 when nothing issues.
  always_comb begin
    e1_d = e1_q;
    e2_d = e2_q;
    e3_d = e3_q;
    wb_d = wb_q;
    if (pipe_en_i) begin
      e1_d.v   = id_valid_i & id_wf_i & issue;
      e1_d.num = id_fd_i;
      e1_d.fc  = id_fc_i;
      e2_d     = e1_q;
      e3_d     = e2_q;
      wb_d.v   = e3_q.v;
      wb_d.num = e3_q.num;
    end
  end

  // Iterative unit countdown runs independently of pipe_en.
  always_comb begin
    ds_cnt_d  = ds_cnt_q;
    ds_busy_d = ds_busy_q;
    if (issue && is_ds_op) begin
      ds_cnt_d  = (id_fc_i == FC_DIV) ? DS_W'(DIV_LAT) : DS_W'(SQRT_LAT);
      ds_busy_d = 1'b1;
    end else if (ds_cnt_q != '0) begin
      ds_cnt_d  = ds_cnt_q - DS_W'(1);
      ds_busy_d = (ds_cnt_q != DS_W'(1));
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (st_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1_q        <= '0;
      e2_q        <= '0;
      e3_q        <= '0;
      wb_q        <= '0;
      ds_busy_q   <= 1'b0;
      ds_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      e3_q        <= e3_d;
      wb_q        <= wb_d;
      ds_busy_q   <= ds_busy_d;
      ds_cnt_q    <= ds_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Testbench for fpu_issue_scheduler: directed scenarios plus random traffic,
// all checked against a stage-list reference model.
module tb_fpu_issue_scheduler;

  localparam int unsigned CNT_W   = 16;
  localparam int          LAT     = 14;
  localparam int          SAT     = 65535;
  localparam logic [2:0]  ADD     = 3'b000;
  localparam logic [2:0]  DIV     = 3'b100;
  localparam logic [2:0]  SQRT    = 3'b110;

  logic             clk = 1'b0;
  logic             clrn;
  logic             id_valid, id_use_fs, id_use_ft, id_wf, pipe_en, flush;
  logic [2:0]       id_fc;
  logic [4:0]       id_fs, id_ft, id_fd;
  logic             st_id, iss_wf, ds_busy;
  logic [1:0]       fwd_a, fwd_b;
  logic [4:0]       ds_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: index 0 = E1 (youngest) .. 3 = WB (oldest).
  logic       mv[4];
  logic [4:0] mn[4];
  int         m_ds;
  int         m_sc;
  logic       x_st, x_iw, x_issue;
  logic [1:0] x_fa, x_fb;

  always #5 clk = ~clk;

  fpu_issue_scheduler #(.DIV_LAT(14), .SQRT_LAT(14), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn),
    .id_valid_i(id_valid), .id_fc_i(id_fc),
    .id_fs_i(id_fs), .id_use_fs_i(id_use_fs),
    .id_ft_i(id_ft), .id_use_ft_i(id_use_ft),
    .id_fd_i(id_fd), .id_wf_i(id_wf),
    .pipe_en_i(pipe_en), .flush_i(flush),
    .st_id_o(st_id), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .iss_wf_o(iss_wf),
    .ds_busy_o(ds_busy), .ds_cnt_o(ds_cnt), .stall_cnt_o(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      mn[k] = '0;
    end
    m_ds = 0;
    m_sc = 0;
  endtask

  // Find the youngest stage holding source s and map it to an action.
  task automatic lookup(input logic u, input logic [4:0] s, output logic stall, output logic [1:0] f);
    int hit;
    hit = -1;
    if (u) begin
      for (int k = 0; k < 4; k++) begin
        if (hit < 0 && mv[k] && mn[k] == s) hit = k;
      end
    end
    stall = (hit == 0 || hit == 1);
    f = (hit == 2) ? 2'b01 : (hit == 3) ? 2'b10 : 2'b00;
  endtask

  task automatic predict();
    logic sa, sb, structural;
    lookup(id_use_fs, id_fs, sa, x_fa);
    lookup(id_use_ft, id_ft, sb, x_fb);
    structural = (id_fc == DIV || id_fc == SQRT) && m_ds > 0;
    x_st    = id_valid && !flush && (sa || sb || structural);
    x_issue = id_valid && !flush && !x_st && pipe_en;
    x_iw    = id_wf && x_issue;
  endtask

  task automatic check_all(input string tag);
    predict();
    chk({tag, ".st_id"},     32'(st_id),     32'(x_st));
    chk({tag, ".fwd_a"},     32'(fwd_a),     32'(x_fa));
    chk({tag, ".fwd_b"},     32'(fwd_b),     32'(x_fb));
    chk({tag, ".iss_wf"},    32'(iss_wf),    32'(x_iw));
    chk({tag, ".ds_busy"},   32'(ds_busy),   32'(m_ds > 0));
    chk({tag, ".ds_cnt"},    32'(ds_cnt),    32'(m_ds));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
  endtask

  task automatic drive(input string tag, input logic v, input logic [2:0] fc,
                       input logic [4:0] fs, input logic ufs,
                       input logic [4:0] ft, input logic uft,
                       input logic [4:0] fd, input logic wf,
                       input logic pen, input logic fl);
    @(negedge clk);
    id_valid = v; id_fc = fc; id_fs = fs; id_use_fs = ufs; id_ft = ft;
    id_use_ft = uft; id_fd = fd; id_wf = wf; pipe_en = pen; flush = fl;
    #1;
    check_all(tag);
  endtask

  // Advance one clock and update the model with the pre-edge decision.
  task automatic tick();
    @(posedge clk);
    predict();
    if (pipe_en) begin
      for (int k = 3; k > 0; k--) begin
        mv[k] = mv[k-1];
        mn[k] = mn[k-1];
      end
      mv[0] = id_valid && id_wf && x_issue;
      mn[0] = id_fd;
    end
    if (x_issue && (id_fc == DIV || id_fc == SQRT)) m_ds = LAT;
    else if (m_ds > 0) m_ds--;
    if (x_st && m_sc < SAT) m_sc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive("idle", 1'b0, ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic apply_reset();
    #2;
    clrn = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    chk("reset.ds_cnt0", 32'(ds_cnt), 32'd0);
    chk("reset.busy0",   32'(ds_busy), 32'd0);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    model_reset();
    clrn = 1'b0;
    id_valid = 1'b1; id_fc = ADD; id_fs = 5'd1; id_use_fs = 1'b1; id_ft = 5'd2;
    id_use_ft = 1'b1; id_fd = 5'd3; id_wf = 1'b1; pipe_en = 1'b1; flush = 1'b0;
    #1;
    check_all("por");
    chk("por.st_id",  32'(st_id),  32'd0);
    chk("por.iss_wf", 32'(iss_wf), 32'd1);
    chk("por.fwd_a",  32'(fwd_a),  32'd0);
    @(posedge clk);
    #2;
    clrn = 1'b1;

    // Back-to-back dependency: two stall cycles, then forward from E3.
    idle(4);
    drive("s1.prod", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    chk("s1.prod_iss", 32'(iss_wf), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive("s1.cons", 1'b1, ADD, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
      chk("s1.stall", 32'(st_id), 32'd1);
      tick();
    end
    drive("s1.cons", 1'b1, ADD, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    chk("s1.go",    32'(st_id), 32'd0);
    chk("s1.fwd_a", 32'(fwd_a), 32'd1);
    chk("s1.fwd_b", 32'(fwd_b), 32'd0);
    tick();

    // Producer aged into WB forwards from wd; one cycle later the regfile.
    idle(4);
    drive("s2.prod", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive("s2.gap", 1'b1, ADD, 5'd8, 1'b1, 5'd9, 1'b1, 5'(20 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    drive("s2.wb", 1'b1, ADD, 5'd3, 1'b1, 5'd9, 1'b1, 5'd30, 1'b1, 1'b1, 1'b0);
    chk("s2.wb_st",  32'(st_id), 32'd0);
    chk("s2.wb_fwd", 32'(fwd_a), 32'd2);
    tick();
    drive("s2.rf", 1'b1, ADD, 5'd3, 1'b1, 5'd9, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0);
    chk("s2.rf_fwd", 32'(fwd_a), 32'd0);
    tick();

    // fdiv then fsqrt: structural stall while the unit counts down.
    idle(4);
    drive("s3.div", 1'b1, DIV, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    chk("s3.div_st", 32'(st_id), 32'd0);
    tick();
    for (int i = 0; i < LAT; i++) begin
      drive("s3.sqrt", 1'b1, SQRT, 5'd11, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
      chk("s3.cnt",  32'(ds_cnt), 32'(LAT - i));
      chk("s3.stall", 32'(st_id), 32'd1);
      tick();
    end
    drive("s3.sqrt", 1'b1, SQRT, 5'd11, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    chk("s3.go",   32'(st_id),   32'd0);
    chk("s3.idle", 32'(ds_busy), 32'd0);
    tick();

    // f7 in both E3 and WB: youngest (E3) wins on both ports.
    idle(16);
    drive("s4.a", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive("s4.b", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive("s4.fill", 1'b1, ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'(20 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    drive("s4.cons", 1'b1, ADD, 5'd7, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
    chk("s4.fwd_a", 32'(fwd_a), 32'd1);
    chk("s4.fwd_b", 32'(fwd_b), 32'd1);
    tick();

    // Frozen pipe keeps the hazard; flush drops the stall and the issue.
    idle(4);
    drive("s5.prod", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive("s5.hold", 1'b1, ADD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      chk("s5.stall", 32'(st_id), 32'd1);
      tick();
    end
    drive("s5.flush", 1'b1, ADD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    chk("s5.fl_st", 32'(st_id),  32'd0);
    chk("s5.fl_wf", 32'(iss_wf), 32'd0);
    tick();
    drive("s5.resume", 1'b1, ADD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    chk("s5.still_e1", 32'(st_id), 32'd1);
    tick();

    // Random traffic on a small register window to provoke hazards.
    idle(4);
    for (int i = 0; i < 1500; i++) begin
      drive("rnd", 1'($urandom_range(0, 9) < 8), 3'($urandom_range(0, 6)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 9) == 0));
      tick();
    end

    // Saturation of the stall counter after a fresh reset.
    apply_reset();
    drive("s6.prod", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    drive("s6.hold", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
    drive("s6.sat", 1'b1, ADD, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("s6.sat_cnt", 32'(stall_cnt), 32'hFFFF);
    tick();

    // Reset during a division clears all tracking.
    idle(4);
    drive("s7.div", 1'b1, DIV, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive("s7.run", 1'b0, ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("s7.busy_pre", 32'(ds_busy), 32'd1);
    apply_reset();
    drive("s7.after", 1'b1, SQRT, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    chk("s7.after_st", 32'(st_id), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
